// File: rtl/adder_err_eval_pkg.sv
// Shared types, default parameters and the error metric helper for the
// approximate-adder error-evaluation controller.
package adder_err_eval_pkg;

    localparam int          DEF_WIDTH     = 16;
    localparam int          DEF_ACC_W     = 48;
    localparam logic [31:0] DEF_LFSR_TAPS = 32'h8020_0003;

    // Widest sum abs_diff handles; callers zero-extend into it and truncate back.
    localparam int          MAX_SUM_W     = 33;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [MAX_SUM_W-1:0] abs_diff(
        input logic [MAX_SUM_W-1:0] exact,
        input logic [MAX_SUM_W-1:0] approx
    );
        return (exact >= approx) ? (exact - approx) : (approx - exact);
    endfunction

endpackage

// File: rtl/adder_err_eval_ctrl_opgen_lfsr.sv
// Operand generator: {op_b,op_a} register stepped either as a Galois LFSR
// or as a wrapping counter; mode is captured at load time.
module opgen_lfsr
    import adder_err_eval_pkg::*;
#(
    parameter int                 WIDTH     = DEF_WIDTH,
    parameter logic [2*WIDTH-1:0] LFSR_TAPS = (2*WIDTH)'(DEF_LFSR_TAPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               mode,
    input  logic [2*WIDTH-1:0] seed,
    output logic [2*WIDTH-1:0] value
);

    logic               mode_q;
    logic [2*WIDTH-1:0] next_lfsr;

    always_comb begin
        next_lfsr = (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value  <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            mode_q <= mode;
            // An all-zero LFSR would lock up, so seed 0 becomes 1 in random mode.
            if (!mode && (seed == '0)) begin
                value <= (2*WIDTH)'(1);
            end else begin
                value <= seed;
            end
        end else if (step) begin
            value <= mode_q ? (value + (2*WIDTH)'(1)) : next_lfsr;
        end
    end

endmodule

// File: rtl/adder_err_eval_ctrl.sv
// Sequencer and error accumulator for characterising one approximate adder:
// issues operand pairs, compares the returned sum with the exact sum, and
// accumulates error count, maximum and summed absolute error.
module adder_err_eval_ctrl
    import adder_err_eval_pkg::*;
#(
    parameter int                 WIDTH     = DEF_WIDTH,
    parameter int                 ACC_W     = DEF_ACC_W,
    parameter logic [2*WIDTH-1:0] LFSR_TAPS = (2*WIDTH)'(DEF_LFSR_TAPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [2*WIDTH-1:0] seed,
    input  logic [31:0]        num_samples,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH:0]     approx_sum,
    output logic               busy,
    output logic               done,
    output logic [31:0]        err_count,
    output logic [WIDTH:0]     max_abs_err,
    output logic [ACC_W-1:0]   sum_abs_err
);

    state_t             state, state_nxt;
    logic               gen_load, gen_step, clear_acc, flush;
    logic [2*WIDTH-1:0] gen_value;
    logic [31:0]        n_q, issued_q;
    logic               v0, v1;
    logic [WIDTH:0]     exact, abs_now, abs_s1;
    logic [ACC_W:0]     sum_ext;

    opgen_lfsr #(
        .WIDTH     (WIDTH),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_opgen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (gen_load),
        .step  (gen_step),
        .mode  (mode),
        .seed  (seed),
        .value (gen_value)
    );

    assign op_a = gen_value[WIDTH-1:0];
    assign op_b = gen_value[2*WIDTH-1:WIDTH];

    always_comb begin
        exact   = {1'b0, op_a} + {1'b0, op_b};
        abs_now = (WIDTH+1)'(abs_diff(MAX_SUM_W'(exact), MAX_SUM_W'(approx_sum)));
        sum_ext = {1'b0, sum_abs_err} + (ACC_W+1)'(abs_s1);
    end

    always_comb begin
        state_nxt = state;
        gen_load  = 1'b0;
        gen_step  = 1'b0;
        clear_acc = 1'b0;
        flush     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    clear_acc = 1'b1;
                    if (num_samples == 32'd0) begin
                        state_nxt = DONE;
                    end else begin
                        gen_load  = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    flush     = 1'b1;
                    state_nxt = IDLE;
                end else if (issued_q == n_q) begin
                    state_nxt = DRAIN;
                end else begin
                    gen_step = 1'b1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush     = 1'b1;
                    state_nxt = IDLE;
                end else if (!v0) begin
                    // The last S1 entry is consumed on this same edge.
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            n_q         <= '0;
            issued_q    <= '0;
            v0          <= 1'b0;
            v1          <= 1'b0;
            abs_s1      <= '0;
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done  <= (state_nxt == DONE);

            if (clear_acc) begin
                n_q <= num_samples;
            end
            if (gen_load) begin
                issued_q <= 32'd1;
            end else if (gen_step) begin
                issued_q <= issued_q + 32'd1;
            end

            if (flush) begin
                v0 <= 1'b0;
                v1 <= 1'b0;
            end else begin
                v0 <= gen_load || gen_step;
                v1 <= v0;
            end
            abs_s1 <= abs_now;

            if (clear_acc) begin
                err_count   <= '0;
                max_abs_err <= '0;
                sum_abs_err <= '0;
            end else if (v1 && !flush) begin
                if ((abs_s1 != '0) && (err_count != '1)) begin
                    err_count <= err_count + 32'd1;
                end
                if (abs_s1 > max_abs_err) begin
                    max_abs_err <= abs_s1;
                end
                sum_abs_err <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            end
        end
    end

endmodule

// File: doc/adder_err_eval_ctrl.md
Name: adder_err_eval_ctrl

Overview:
- Sequencer and error accumulator for characterising one approximate adder instance (WIDTH-bit operands, WIDTH+1-bit sum).
- Generates operand pairs, drives them into the external approximate adder, and samples its sum in the same cycle.
- Compares that sum against an internal exact sum and accumulates error count, maximum absolute error and summed absolute error.
- Sits beside the adder under evaluation in the error-evaluation harness; software/testbench starts a run and reads the three metrics.

Parameters:
WIDTH, 16, operand width; sums are WIDTH+1 bits
ACC_W, 48, width of sum_abs_err accumulator
LFSR_TAPS, 32'h80200003, Galois feedback mask for the 2*WIDTH-bit LFSR

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled only in IDLE/DONE
abort  in  1  terminate run, sampled in RUN/DRAIN
mode  in  1  0 = LFSR random operands, 1 = exhaustive counter
seed  in  2*WIDTH  initial generator value, split as {b,a}
num_samples  in  32  operand pairs per run, captured at start
op_a  out  WIDTH  operand A to adder under evaluation (registered)
op_b  out  WIDTH  operand B to adder under evaluation (registered)
approx_sum  in  WIDTH+1  combinational result of adder under evaluation
busy  out  1  run in progress
done  out  1  level; results valid, held until next start
err_count  out  32  samples with nonzero error, saturating
max_abs_err  out  WIDTH+1  largest |exact-approx|
sum_abs_err  out  ACC_W  sum of |exact-approx|, saturating

Behaviour:
- Reset (async, rst_n=0): state IDLE; op_a, op_b, err_count, max_abs_err, sum_abs_err all 0; busy=0, done=0; valid pipe cleared. Reset mid-run discards the run.
- States: IDLE, RUN, DRAIN, DONE. DONE behaves like IDLE except done=1.
- IDLE/DONE with start=1 and abort=0, at edge E0:
  - Clear accumulators; done<=0; latch num_samples.
  - If num_samples==0: go to DONE with done=1 and zero results; busy never asserts.
  - Otherwise: load generator; drive first pair onto op_a/op_b; busy<=1; go to RUN.
- Generator, mode 1: {op_b,op_a} = seed, then +1 per sample, wrapping modulo 2^(2*WIDTH).
- Generator, mode 0: Galois LFSR over {op_b,op_a}. Seed 0 is replaced by 1. Each step: shift right; if the shifted-out bit was 1, XOR LFSR_TAPS.
- RUN: one new pair per cycle. Sample i is on op_a/op_b during the cycle after edge E0+i.
  - exact = op_a+op_b (WIDTH+1 bits) and approx_sum are compared that cycle; |exact-approx| is registered at stage S1 (edge E0+i+1).
  - Accumulators update at edge E0+i+2.
  - After N pairs have been issued, go to DRAIN; op_a/op_b hold their last value.
- DRAIN: wait until the 2-stage valid pipe is empty, then go to DONE. At that edge done<=1 and busy<=0, i.e. edge E0+N+1; busy is high for N+1 cycles.
- Accumulate, per valid S1 entry:
  - err_count += (abs!=0).
  - max_abs_err = max(max_abs_err, abs).
  - sum_abs_err += abs.
  - err_count and sum_abs_err saturate at all-ones; they never wrap.
- Simultaneous events:
  - start in RUN/DRAIN: ignored.
  - abort in RUN/DRAIN: go to IDLE next edge; valid pipe flushed; busy=0, done=0; partial metrics held until next start.
  - start and abort in the same IDLE/DONE cycle: abort wins and start is ignored. State becomes IDLE and done clears.

Decomposition:
- Package adder_err_eval_pkg: state enum (IDLE, RUN, DRAIN, DONE), default WIDTH, ACC_W, LFSR_TAPS, and a function abs_diff(exact, approx).
- One sub-module, opgen_lfsr: operand generator with load/step/mode, 2*WIDTH-bit state, seed-zero substitution.
- FSM, S1 pipe and accumulators remain in the top module.

Test Plan:
1. Exact match: mode=1, seed=0, num_samples=4, approx_sum tied to op_a+op_b -> done after E0+5, busy high 5 cycles, err_count=0, max_abs_err=0, sum_abs_err=0.
2. LSB-dropped model: mode=1, seed=0, num_samples=8, approx_sum=(op_a+op_b)&~1 -> pairs a=0..7, b=0; err_count=4, max_abs_err=1, sum_abs_err=4.
3. Zero samples: num_samples=0, start -> done=1 one edge later, busy never 1, all metrics 0.
4. Abort: num_samples=100, assert abort 3 cycles into RUN -> busy=0 next edge, done=0, partial metrics held. A following start clears metrics and completes normally.
5. Random mode: mode=0, seed=0 -> first pair {b,a}=32'h00000001, next pairs follow the LFSR_TAPS model. start pulsed mid-run -> no restart and the op sequence is undisturbed.
6. Saturation and reset: ACC_W=20, approx_sum=0, op sums near 2^17, num_samples=16 -> sum_abs_err=20'hFFFFF. rst_n dropped mid-run -> all outputs 0 immediately, state IDLE.
